// File: rtl/m20k_fifo_pkg.sv
// Shared constants and types for the M20K-backed FIFO controller.
// Defaults match the 20-bit x 1024 registered simple dual-port block.
package m20k_fifo_pkg;

    localparam int M20K_WIDTH     = 20;
    localparam int M20K_ADDR_BITS = 10;
    localparam int M20K_RD_LAT    = 2;
    localparam int M20K_SKID      = 4;

    typedef logic [M20K_ADDR_BITS:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_skid_buffer.sv
// Small circular output buffer that absorbs returning memory reads
// and presents a valid/ready head word to the consumer.
module fifo_skid_buffer #(
    parameter int WIDTH      = 20,
    parameter int SKID_DEPTH = 4,
    localparam int CW        = $clog2(SKID_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[head_q] : '0;
    assign count_o = count_q;

    // Pointer and occupancy next-state; capture and pop may coincide.
    always_comb begin
        pop     = valid_o && ready_i;
        head_d  = pop ? nxt(head_q) : head_q;
        tail_d  = push_i ? nxt(tail_q) : tail_q;
        count_d = count_q;
        if (push_i && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state; storage contents are left alone on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Word storage written at the tail on every capture.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= data_i;
        end
    end

    // Upstream read credit must keep captures from overrunning the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && !pop && count_q == CW'(SKID_DEPTH)))
            else $error("skid buffer overrun");
        end
    end

endmodule

// File: rtl/m20k_fifo_controller.sv
// Drives an external registered M20K as a FIFO: push port to memory
// writes, credit-limited reads into an output skid buffer.
module m20k_fifo_controller
    import m20k_fifo_pkg::*;
#(
    parameter int WIDTH        = M20K_WIDTH,
    parameter int ADDR_BITS    = M20K_ADDR_BITS,
    parameter int READ_LATENCY = M20K_RD_LAT,
    parameter int SKID_DEPTH   = M20K_SKID
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 writeEnable,
    input  logic [WIDTH-1:0]     writeData,
    output logic                 full,
    output logic                 overflow,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [WIDTH-1:0]     outData,
    output logic                 memWriteEnable,
    output logic [ADDR_BITS-1:0] memWriteAddr,
    output logic [1:0]           memWriteMask,
    output logic [WIDTH-1:0]     memWriteData,
    output logic                 memReadEnable,
    output logic [ADDR_BITS-1:0] memReadAddr,
    input  logic [WIDTH-1:0]     memReadData
);

    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam fifo_ptr_t CAP = {1'b1, {ADDR_BITS{1'b0}}};

    if (ADDR_BITS != M20K_ADDR_BITS) begin : g_bad_addr
        $error("ADDR_BITS must match fifo_ptr_t");
    end
    if (SKID_DEPTH < READ_LATENCY + 1) begin : g_bad_skid
        $error("SKID_DEPTH too small for READ_LATENCY");
    end

    fifo_ptr_t               wrPtr_q, wrPtr_d;
    fifo_ptr_t               rdPtr_q, rdPtr_d;
    fifo_ptr_t               used;
    logic                    overflow_q, overflow_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [CW-1:0]           skidCount;
    logic [CW:0]             occ;
    logic                    push, issue, credit;

    // Occupancy, push/issue decisions and next-state for pointers/pipe.
    // used comes from registered pointers, so a fresh word waits a cycle.
    always_comb begin
        used   = wrPtr_q - rdPtr_q;
        full   = (used == CAP);
        push   = writeEnable && !full && !rst;
        occ    = {1'b0, skidCount};
        for (int i = 0; i < READ_LATENCY; i++) begin
            occ = occ + (CW + 1)'(pipe_q[i]);
        end
        credit = (occ < (CW + 1)'(SKID_DEPTH));
        issue  = !rst && (used != '0) && credit;

        wrPtr_d    = push ? wrPtr_q + fifo_ptr_t'(1) : wrPtr_q;
        rdPtr_d    = issue ? rdPtr_q + fifo_ptr_t'(1) : rdPtr_q;
        overflow_d = overflow_q || (writeEnable && full);
        pipe_d     = '0;
        pipe_d[0]  = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign overflow       = overflow_q;
    assign memWriteEnable = push;
    assign memWriteAddr   = wrPtr_q[ADDR_BITS-1:0];
    assign memWriteMask   = 2'b11;
    assign memWriteData   = writeData;
    assign memReadEnable  = issue;
    assign memReadAddr    = rdPtr_q[ADDR_BITS-1:0];

    // Pointer, sticky flag and read-return pipe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
            pipe_q     <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            overflow_q <= overflow_d;
            pipe_q     <= pipe_d;
        end
    end

    fifo_skid_buffer #(
        .WIDTH      (WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pipe_q[READ_LATENCY-1]),
        .data_i  (memReadData),
        .ready_i (outReady),
        .valid_o (outValid),
        .data_o  (outData),
        .count_o (skidCount)
    );

endmodule

// File: tb/tb_m20k_fifo_controller.sv
// Directed bench for m20k_fifo_controller with a behavioural
// registered M20K model and an in-order scoreboard.
module tb_m20k_fifo_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        writeEnable = 1'b0;
    logic [19:0] writeData = '0;
    logic        full, overflow, outValid;
    logic        outReady = 1'b0;
    logic [19:0] outData;
    logic        memWriteEnable;
    logic [9:0]  memWriteAddr;
    logic [1:0]  memWriteMask;
    logic [19:0] memWriteData;
    logic        memReadEnable;
    logic [9:0]  memReadAddr;
    logic [19:0] memReadData = '0;

    always #5 clk = ~clk;

    m20k_fifo_controller dut (
        .clk            (clk),
        .rst            (rst),
        .writeEnable    (writeEnable),
        .writeData      (writeData),
        .full           (full),
        .overflow       (overflow),
        .outValid       (outValid),
        .outReady       (outReady),
        .outData        (outData),
        .memWriteEnable (memWriteEnable),
        .memWriteAddr   (memWriteAddr),
        .memWriteMask   (memWriteMask),
        .memWriteData   (memWriteData),
        .memReadEnable  (memReadEnable),
        .memReadAddr    (memReadAddr),
        .memReadData    (memReadData)
    );

    // Registered simple dual-port memory: 2-cycle read, zero when idle.
    logic [19:0] mem [1024];
    logic        rdEn1 = 1'b0;
    logic [9:0]  rdAddr1 = '0;
    always @(posedge clk) begin
        if (memWriteEnable) mem[memWriteAddr] <= memWriteData;
        rdEn1       <= memReadEnable;
        rdAddr1     <= memReadAddr;
        memReadData <= rdEn1 ? mem[rdAddr1] : 20'h0;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pops = 0;
    int first_pop = -1;
    int last_pop = -1;
    int wraps = 0;
    int drops = 0;
    bit track_drop = 0;
    logic [9:0] exp_raddr = '0;
    logic [19:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic we, input logic [19:0] wd,
                        input logic rdy);
        @(negedge clk);
        writeEnable = we;
        writeData   = wd;
        outReady    = rdy;
        #1;
        cyc++;
        if (track_drop && q.size() > 0 && !outValid) drops++;
        if (memReadEnable) begin
            chk("raddr", {22'd0, memReadAddr}, {22'd0, exp_raddr});
            if (exp_raddr == 10'd1023) wraps++;
            exp_raddr = exp_raddr + 10'd1;
        end
        if (we && !full) q.push_back(wd);
        if (outValid && rdy) begin
            if (q.size() == 0) chk("spurious", 32'd1, 32'd0);
            else chk("data", {12'd0, outData}, {12'd0, q.pop_front()});
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_full",  {31'd0, full},           32'd0);
        chk("rst_ovf",   {31'd0, overflow},       32'd0);
        chk("rst_valid", {31'd0, outValid},       32'd0);
        chk("rst_data",  {12'd0, outData},        32'd0);
        chk("rst_mwe",   {31'd0, memWriteEnable}, 32'd0);
        chk("rst_mre",   {31'd0, memReadEnable},  32'd0);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    endtask

    int base;
    logic [15:0] lf;

    initial begin
        // Power-on reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_state();
        chk("mask", {30'd0, memWriteMask}, 32'd3);

        // Five words streamed straight through.
        base = cyc; first_pop = -1; pops = 0;
        for (int i = 1; i <= 5; i++) step(1'b1, 20'(i), 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
        chk("lat",   32'(first_pop - base), 32'd5);
        chk("burst", 32'(last_pop - base),  32'd9);
        chk("pops1", 32'(pops), 32'd5);

        // Fill: 1024 in memory plus 4 held in the skid buffer.
        for (int i = 0; i < 1028; i++) begin
            step(1'b1, 20'(32'h5A5A5 ^ i), 1'b0);
            if (i == 1027) chk("nfull", {31'd0, full}, 32'd0);
        end
        step(1'b0, '0, 1'b0);
        chk("full", {31'd0, full}, 32'd1);
        chk("ovf0", {31'd0, overflow}, 32'd0);
        step(1'b1, 20'hABCDE, 1'b0);
        chk("ovf_mwe", {31'd0, memWriteEnable}, 32'd0);
        step(1'b0, '0, 1'b0);
        chk("ovf", {31'd0, overflow}, 32'd1);
        chk("full2", {31'd0, full}, 32'd1);

        // Pop one: the slot frees once the refill read issues.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("full_hold", {31'd0, full}, 32'd1);
        step(1'b0, '0, 1'b0);
        chk("full_clr", {31'd0, full}, 32'd0);
        step(1'b1, 20'h55555, 1'b0);
        chk("push_ok", {31'd0, memWriteEnable}, 32'd1);
        drain(1200);
        chk("drain3", 32'(q.size()), 32'd0);
        chk("empty3", {31'd0, outValid}, 32'd0);

        // 3000 words streamed across pointer wrap.
        wraps = 0;
        for (int i = 0; i < 3000; i++) step(1'b1, 20'(i * 7 + 3), 1'b1);
        drain(50);
        chk("drain4", 32'(q.size()), 32'd0);
        chk("wrap", 32'(wraps), 32'd2);

        // Prefill, then consume with a pseudo-random ready pattern.
        for (int i = 0; i < 30; i++) step(1'b1, 20'(32'hC0000 + i), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        lf = 16'hACE1; drops = 0; track_drop = 1;
        for (int i = 0; i < 400 && q.size() > 0; i++) begin
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
            step(1'b0, '0, lf[0]);
        end
        track_drop = 0;
        chk("nodrop", 32'(drops), 32'd0);
        chk("drain5", 32'(q.size()), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);

        // Reset with two reads in flight and two words buffered.
        for (int i = 0; i < 5; i++) step(1'b1, 20'(32'h70 + i), 1'b0);
        @(negedge clk);
        writeEnable = 1'b0;
        outReady = 1'b0;
        #1;
        chk("pre_valid", {31'd0, outValid}, 32'd1);
        chk("credit", {31'd0, memReadEnable}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_raddr = '0;
        #1;
        chk_reset_state();
        pops = 0;
        step(1'b1, 20'h12345, 1'b1);
        chk("waddr0", {22'd0, memWriteAddr}, 32'd0);
        chk("wen0", {31'd0, memWriteEnable}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        chk("pops6", 32'(pops), 32'd1);
        chk("drain6", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
